// File: rtl/cache_assoc_ctrl_pkg.sv
// Shared definitions for the fully associative cache controller.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths (match the 32x8 memory)
//   CNT_W                   : width of the hit / miss counters
//   state_e                 : controller FSM state encoding
package cache_assoc_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCheck    = 3'd1,
        StWb       = 3'd2,
        StFill     = 3'd3,
        StFillWait = 3'd4,
        StDone     = 3'd5
    } state_e;

endpackage

// File: rtl/cache_lru.sv
// Age-based LRU tracker for a fully associative cache.
// Ages always form a permutation of 0..LINES-1; age 0 is most recently used.
//   clock, reset : rising-edge clock, asynchronous active-high reset (age[i] = i)
//   touch        : mark line touch_idx as most recently used this cycle
//   touch_idx    : index of the line being touched
//   victim_idx   : index of the line whose age is LINES-1 (least recently used)
module cache_lru
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int unsigned LINES = 4,
    parameter int unsigned AGE_W = $clog2(LINES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             touch,
    input  logic [AGE_W-1:0] touch_idx,
    output logic [AGE_W-1:0] victim_idx
);

    logic [AGE_W-1:0] age_q [LINES];
    logic [AGE_W-1:0] age_d [LINES];

    // Lines younger than the touched one age by one; the touched line becomes 0.
    always_comb begin
        age_d = age_q;
        if (touch) begin
            for (int i = 0; i < LINES; i++) begin
                if (AGE_W'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        victim_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (age_q[i] == AGE_W'(LINES - 1)) begin
                victim_idx = AGE_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                age_q[i] <= AGE_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cache_assoc_ctrl.sv
// Fully associative, write-back, write-allocate cache controller in front of a
// single-port memory with registered address (q valid the cycle after the address).
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   req, wren, address,
//   data                  : request strobe (taken when busy=0), write flag, address, write data
//   q, done, hit, busy    : read data, one-cycle completion pulse, hit flag, request in flight
//   mem_address, mem_data,
//   mem_wren, mem_q       : memory port (owned by this block)
//   hit_cnt, miss_cnt     : wrapping 8-bit hit / miss counters
module cache_assoc_ctrl
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LINES  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              done,
    output logic              hit,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned AGE_W = $clog2(LINES);

    state_e state_q, state_d;

    logic              req_wren_q, req_wren_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [AGE_W-1:0]  victim_q, victim_d;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [ADDR_W-1:0] tag_q [LINES];
    logic [ADDR_W-1:0] tag_d [LINES];
    logic [DATA_W-1:0] line_data_q [LINES];
    logic [DATA_W-1:0] line_data_d [LINES];

    logic [DATA_W-1:0] q_q, q_d;
    logic              hit_q, hit_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic              lookup_hit;
    logic [AGE_W-1:0]  hit_idx;
    logic              have_invalid;
    logic [AGE_W-1:0]  free_idx;
    logic [AGE_W-1:0]  lru_victim;
    logic [AGE_W-1:0]  victim_pick;
    logic              victim_dirty;

    logic              touch;
    logic [AGE_W-1:0]  touch_idx;
    logic              fill_en;
    logic [AGE_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              fill_dirty;

    cache_lru #(
        .LINES (LINES),
        .AGE_W (AGE_W)
    ) u_lru (
        .clock      (clock),
        .reset      (reset),
        .touch      (touch),
        .touch_idx  (touch_idx),
        .victim_idx (lru_victim)
    );

    // Tag compare: the whole address is the tag, so at most one line matches.
    always_comb begin
        lookup_hit = 1'b0;
        hit_idx    = '0;
        for (int i = 0; i < LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
                lookup_hit = 1'b1;
                hit_idx    = AGE_W'(i);
            end
        end
    end

    // Descending scan so the lowest-index invalid line wins.
    always_comb begin
        have_invalid = 1'b0;
        free_idx     = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_invalid = 1'b1;
                free_idx     = AGE_W'(i);
            end
        end
    end

    assign victim_pick  = have_invalid ? free_idx : lru_victim;
    assign victim_dirty = valid_q[victim_pick] && dirty_q[victim_pick];

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (req) state_d = StCheck;
            StCheck: begin
                if (lookup_hit)        state_d = StDone;
                else if (victim_dirty) state_d = StWb;
                else if (req_wren_q)   state_d = StDone;
                else                   state_d = StFill;
            end
            StWb:       state_d = req_wren_q ? StDone : StFill;
            StFill:     state_d = StFillWait;
            StFillWait: state_d = StDone;
            StDone:     state_d = req ? StCheck : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM: outputs toward the requester and the memory
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        unique case (state_q)
            StCheck:    busy = 1'b1;
            StWb: begin
                busy        = 1'b1;
                mem_wren    = 1'b1;
                mem_address = tag_q[victim_q];
                mem_data    = line_data_q[victim_q];
            end
            StFill: begin
                busy        = 1'b1;
                mem_address = req_addr_q;
            end
            StFillWait: busy = 1'b1;
            StDone:     done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: request capture, line updates, result and counters.
    always_comb begin
        req_wren_d  = req_wren_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        victim_d    = victim_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        line_data_d = line_data_q;
        q_d         = q_q;
        hit_d       = hit_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        touch       = 1'b0;
        touch_idx   = '0;
        fill_en     = 1'b0;
        fill_idx    = '0;
        fill_data   = '0;
        fill_dirty  = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (req) begin
                    req_wren_d = wren;
                    req_addr_d = address;
                    req_data_d = data;
                end
            end
            StCheck: begin
                if (lookup_hit) begin
                    if (req_wren_q) begin
                        line_data_d[hit_idx] = req_data_q;
                        dirty_d[hit_idx]     = 1'b1;
                    end else begin
                        q_d = line_data_q[hit_idx];
                    end
                    hit_d     = 1'b1;
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    touch     = 1'b1;
                    touch_idx = hit_idx;
                end else begin
                    hit_d      = 1'b0;
                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    victim_d   = victim_pick;
                    // Clean write miss installs immediately; the word is fully overwritten.
                    if (!victim_dirty && req_wren_q) begin
                        fill_en    = 1'b1;
                        fill_idx   = victim_pick;
                        fill_data  = req_data_q;
                        fill_dirty = 1'b1;
                    end
                end
            end
            StWb: begin
                if (req_wren_q) begin
                    fill_en    = 1'b1;
                    fill_idx   = victim_q;
                    fill_data  = req_data_q;
                    fill_dirty = 1'b1;
                end
            end
            StFillWait: begin
                fill_en    = 1'b1;
                fill_idx   = victim_q;
                fill_data  = mem_q;
                fill_dirty = 1'b0;
                q_d        = mem_q;
            end
            default: ;
        endcase

        if (fill_en) begin
            valid_d[fill_idx]     = 1'b1;
            dirty_d[fill_idx]     = fill_dirty;
            tag_d[fill_idx]       = req_addr_q;
            line_data_d[fill_idx] = fill_data;
            touch                 = 1'b1;
            touch_idx             = fill_idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_wren_q <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            victim_q   <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]       <= '0;
                line_data_q[i] <= '0;
            end
            q_q        <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            req_wren_q  <= req_wren_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            victim_q    <= victim_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            line_data_q <= line_data_d;
            q_q         <= q_d;
            hit_q       <= hit_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign q        = q_q;
    assign hit      = hit_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Self-checking bench for cache_assoc_ctrl with a 32x8 registered-address memory model
// and a recency-list reference model of the cache.
module tb_cache_assoc_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       wren = 1'b0;
    logic [4:0] address = '0;
    logic [7:0] data = '0;
    logic [7:0] q;
    logic       done, hit, busy;
    logic [4:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic [7:0] mem_q;
    logic [7:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cache_assoc_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .wren        (wren),
        .address     (address),
        .data        (data),
        .q           (q),
        .done        (done),
        .hit         (hit),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    // Single-port memory: address registered at the edge, q read from the registered address.
    logic [7:0] mem [32];
    logic [4:0] mem_addr_reg = '0;
    logic       preload = 1'b0;
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i + 16);
        end else if (mem_wren) begin
            mem[mem_address] <= mem_data;
        end
        mem_addr_reg <= mem_address;
    end
    assign mem_q = mem[mem_addr_reg];

    // Reference model: lines plus a recency list (front = most recently used).
    bit         m_valid [4];
    bit         m_dirty [4];
    logic [4:0] m_tag   [4];
    logic [7:0] m_data  [4];
    int         order[$];
    logic [7:0] model_mem [32];
    logic [7:0] shadow    [32];
    logic [7:0] m_hits, m_misses;

    // Observations from the last transaction
    int         lat, wb_n;
    logic       o_hit;
    logic [7:0] o_q, wb_d;
    logic [4:0] wb_a;

    task automatic apply_reset(input bit do_preload);
        @(negedge clock);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        if (do_preload) begin
            preload = 1'b1;
            @(negedge clock);
            preload = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
        end
        order = {};
        for (int i = 0; i < 4; i++) order.push_back(i);
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = 8'(i + 16);
            shadow[i]    = 8'(i + 16);
        end
        m_hits = '0; m_misses = '0;
    endtask

    task automatic model_step(input bit wr, input logic [4:0] a, input logic [7:0] d,
                              output bit e_hit, output int e_lat, output bit e_wb,
                              output logic [4:0] e_wb_a, output logic [7:0] e_wb_d,
                              output logic [7:0] e_q);
        int k = -1;
        e_wb = 0; e_wb_a = '0; e_wb_d = '0;
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == a) k = i;
        if (k >= 0) begin
            e_hit = 1; e_lat = 2; m_hits = m_hits + 8'd1;
            if (wr) begin m_data[k] = d; m_dirty[k] = 1; end
        end else begin
            e_hit = 0; m_misses = m_misses + 8'd1;
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) k = i;
            if (k < 0) k = order[$];
            if (m_valid[k] && m_dirty[k]) begin
                e_wb = 1; e_wb_a = m_tag[k]; e_wb_d = m_data[k];
                model_mem[m_tag[k]] = m_data[k];
            end
            m_valid[k] = 1; m_tag[k] = a;
            if (wr) begin
                m_data[k] = d; m_dirty[k] = 1; e_lat = e_wb ? 3 : 2;
            end else begin
                m_data[k] = model_mem[a]; m_dirty[k] = 0; e_lat = e_wb ? 5 : 4;
            end
        end
        if (wr) shadow[a] = d;
        e_q = shadow[a];
        for (int j = 0; j < order.size(); j++) begin
            if (order[j] == k) begin order.delete(j); break; end
        end
        order.push_front(k);
    endtask

    // Issue one request and observe latency, result and any memory writes (no checking).
    task automatic do_req(input bit wr, input logic [4:0] a, input logic [7:0] d);
        int guard = 0;
        @(negedge clock);
        while (busy && guard < 50) begin @(negedge clock); guard++; end
        req = 1'b1; wren = wr; address = a; data = d;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        lat = 1; wb_n = 0; wb_a = '0; wb_d = '0; o_hit = 1'bx; o_q = 'x;
        forever begin
            if (mem_wren) begin wb_n++; wb_a = mem_address; wb_d = mem_data; end
            if (done || lat >= 20) break;
            @(negedge clock);
            lat++;
        end
        if (done) begin o_hit = hit; o_q = q; end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++;
        if ({q, done, hit, busy, mem_wren} !== 12'h000) begin
            errors++; $display("FAIL reset_ctrl: got q=%h done=%b hit=%b busy=%b wren=%b want 0",
                               q, done, hit, busy, mem_wren);
        end
        checks++;
        if ({mem_address, mem_data} !== 13'h0) begin
            errors++; $display("FAIL reset_mem: got addr=%h data=%h want 0", mem_address, mem_data);
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== 16'h0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_read_miss_hit();
        apply_reset(1'b1);
        do_req(1'b0, 5'h03, 8'h00);
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL rd_miss_hit: got %b want 0", o_hit); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd_miss_lat: got %0d want 4", lat); end
        checks++; if (o_q !== 8'h13) begin errors++; $display("FAIL rd_miss_q: got %h want 13", o_q); end
        checks++; if (wb_n !== 0) begin errors++; $display("FAIL rd_miss_wren: got %0d want 0", wb_n); end
        do_req(1'b0, 5'h03, 8'h00);
        checks++; if (o_hit !== 1'b1) begin errors++; $display("FAIL rd_hit_hit: got %b want 1", o_hit); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_hit_lat: got %0d want 2", lat); end
        checks++; if (o_q !== 8'h13) begin errors++; $display("FAIL rd_hit_q: got %h want 13", o_q); end
        checks++;
        if (hit_cnt !== 8'd1 || miss_cnt !== 8'd1) begin
            errors++; $display("FAIL rd_counts: got %0d/%0d want 1/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_write_alloc();
        apply_reset(1'b1);
        do_req(1'b1, 5'h07, 8'hAA);
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL wr_miss_hit: got %b want 0", o_hit); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_miss_lat: got %0d want 2", lat); end
        checks++; if (wb_n !== 0) begin errors++; $display("FAIL wr_miss_wren: got %0d want 0", wb_n); end
        do_req(1'b0, 5'h07, 8'h00);
        checks++; if (o_hit !== 1'b1) begin errors++; $display("FAIL wr_rd_hit: got %b want 1", o_hit); end
        checks++; if (o_q !== 8'hAA) begin errors++; $display("FAIL wr_rd_q: got %h want aa", o_q); end
        checks++; if (mem[7] !== 8'h17) begin errors++; $display("FAIL wr_mem7: got %h want 17", mem[7]); end
    endtask

    task automatic test_lru();
        logic [4:0] seq  [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd1, 5'd4, 5'd0, 5'd1};
        logic       ehit [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, seq[i], 8'h00);
            checks++;
            if (o_hit !== ehit[i] || o_q !== 8'(seq[i] + 5'd0) + 8'h10) begin
                errors++; $display("FAIL lru_step%0d: got hit=%b q=%h want hit=%b q=%h",
                                   i, o_hit, o_q, ehit[i], 8'(seq[i]) + 8'h10);
            end
        end
    endtask

    task automatic test_dirty_evict();
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) do_req(1'b1, 5'(i), 8'h55);
        do_req(1'b0, 5'h10, 8'h00);
        checks++;
        if (wb_n !== 1 || wb_a !== 5'h00 || wb_d !== 8'h55) begin
            errors++; $display("FAIL evict_wb: got n=%0d addr=%h data=%h want 1/00/55", wb_n, wb_a, wb_d);
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL evict_lat: got %0d want 5", lat); end
        checks++; if (o_q !== 8'h20) begin errors++; $display("FAIL evict_q: got %h want 20", o_q); end
        checks++; if (mem[0] !== 8'h55) begin errors++; $display("FAIL evict_mem0: got %h want 55", mem[0]); end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) do_req(1'b1, 5'(i), 8'h66);
        @(negedge clock);
        req = 1'b1; wren = 1'b0; address = 5'h10;
        @(posedge clock);
        #1 req = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_wren} !== 3'b000 || q !== 8'h00 || mem_address !== 5'h00) begin
            errors++; $display("FAIL mid_reset_out: got busy=%b done=%b wren=%b q=%h addr=%h want 0",
                               busy, done, mem_wren, q, mem_address);
        end
        checks++;
        if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
        do_req(1'b0, 5'h01, 8'h00);
        checks++;
        if (o_hit !== 1'b0 || o_q !== 8'h11 || lat !== 4) begin
            errors++; $display("FAIL mid_lost_dirty: got hit=%b q=%h lat=%0d want 0/11/4", o_hit, o_q, lat);
        end
        do_req(1'b0, 5'h00, 8'h00);
        checks++;
        if (o_hit !== 1'b0 || o_q !== 8'h66) begin
            errors++; $display("FAIL mid_written_back: got hit=%b q=%h want 0/66", o_hit, o_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pend[$];
        logic [4:0] cur, exp_a;
        int accepts = 0, dones = 0;
        bit acc;
        apply_reset(1'b1);
        cur = 5'($urandom_range(0, 5));
        @(negedge clock);
        req = 1'b1; wren = 1'b0; address = cur; data = 8'h00;
        for (int c = 0; c < 90; c++) begin
            if (done) begin
                dones++;
                checks++;
                if (pend.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_done: got done with no request pending");
                end else begin
                    exp_a = pend.pop_front();
                    if (q !== 8'(exp_a) + 8'h10) begin
                        errors++; $display("FAIL b2b_q: got %h want %h", q, 8'(exp_a) + 8'h10);
                    end
                end
            end
            acc = !busy;
            if (acc) begin pend.push_back(cur); accepts++; end
            @(posedge clock);
            if (acc) begin
                #1 cur = (cur + 5'($urandom_range(1, 5))) % 5'd6;
                address = cur;
            end
            @(negedge clock);
        end
        req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                dones++;
                checks++;
                if (pend.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_done: got done with no request pending");
                end else begin
                    exp_a = pend.pop_front();
                    if (q !== 8'(exp_a) + 8'h10) begin
                        errors++; $display("FAIL b2b_q: got %h want %h", q, 8'(exp_a) + 8'h10);
                    end
                end
            end
            @(negedge clock);
        end
        checks++;
        if (dones !== accepts || pend.size() != 0) begin
            errors++; $display("FAIL b2b_count: got dones=%0d want %0d", dones, accepts);
        end
        checks++;
        if (accepts < 15) begin
            errors++; $display("FAIL b2b_accepts: got %0d want at least 15", accepts);
        end
    endtask

    task automatic test_random();
        bit         wr, e_hit, e_wb;
        int         e_lat, bad;
        logic [4:0] a, e_wb_a;
        logic [7:0] d, e_wb_d, e_q;
        apply_reset(1'b1);
        model_reset();
        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 7));
            d  = 8'($urandom);
            model_step(wr, a, d, e_hit, e_lat, e_wb, e_wb_a, e_wb_d, e_q);
            do_req(wr, a, d);
            checks++;
            if (o_hit !== e_hit || lat !== e_lat) begin
                errors++; $display("FAIL rnd%0d_hit_lat: got hit=%b lat=%0d want hit=%b lat=%0d",
                                   n, o_hit, lat, e_hit, e_lat);
            end
            checks++;
            if (wb_n !== int'(e_wb) || (e_wb && (wb_a !== e_wb_a || wb_d !== e_wb_d))) begin
                errors++; $display("FAIL rnd%0d_wb: got n=%0d %h/%h want n=%0d %h/%h",
                                   n, wb_n, wb_a, wb_d, e_wb, e_wb_a, e_wb_d);
            end
            if (!wr) begin
                checks++;
                if (o_q !== e_q) begin
                    errors++; $display("FAIL rnd%0d_q: got %h want %h", n, o_q, e_q);
                end
            end
            checks++;
            if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
                errors++; $display("FAIL rnd%0d_cnt: got %0d/%0d want %0d/%0d",
                                   n, hit_cnt, miss_cnt, m_hits, m_misses);
            end
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== model_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rnd_memory: got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_alloc();
        test_lru();
        test_dirty_evict();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
